// File: rtl/fifo_crossbar_switch_pkg.sv
// Shared widths, entry layout and arbitration helper for the input-queued crossbar switch.
package switch_pkg;

  function automatic int dest_w(input int output_qty);
    return (output_qty > 1) ? $clog2(output_qty) : 1;
  endfunction

  function automatic int src_w(input int input_qty);
    return (input_qty > 1) ? $clog2(input_qty) : 1;
  endfunction

  // Round-robin successor: the search after a grant to k starts at k+1.
  function automatic int rr_next(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_OUTPUT_QTY = 8;

  // Entry layout for the default configuration; the switch builds the same shape from its parameters.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0]            data;
    logic [dest_w(DEFAULT_OUTPUT_QTY)-1:0]    dest;
  } fifo_entry_t;

endpackage

// File: rtl/fifo_crossbar_switch_if.sv
// Valid/ready bundle between the crossbar switch and its sources and sinks.
interface fifo_crossbar_switch_if #(
  parameter int DATA_WIDTH = 64,
  parameter int INPUT_QTY  = 8,
  parameter int OUTPUT_QTY = 8
);
  import switch_pkg::*;

  localparam int DEST_W = dest_w(OUTPUT_QTY);
  localparam int SRC_W  = src_w(INPUT_QTY);

  logic [INPUT_QTY-1:0]                  in_valid;
  logic [INPUT_QTY-1:0]                  in_ready;
  logic [INPUT_QTY-1:0][DATA_WIDTH-1:0]  in_data;
  logic [INPUT_QTY-1:0][DEST_W-1:0]      in_dest;
  logic [OUTPUT_QTY-1:0]                 out_valid;
  logic [OUTPUT_QTY-1:0]                 out_ready;
  logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0] out_data;
  logic [OUTPUT_QTY-1:0][SRC_W-1:0]      out_src;
  logic [INPUT_QTY-1:0]                  drop_pulse;

  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data, out_src, drop_pulse
  );

  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_src, drop_pulse
  );
endinterface

// File: rtl/fifo_crossbar_switch_input_fifo.sv
// Single-clock first-word-fall-through FIFO; the head is readable in the cycle it becomes valid.
module switch_input_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (!do_push && do_pop) count_reg <= count_reg - 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
endmodule

// File: rtl/fifo_crossbar_switch.sv
// Input-queued crossbar: per-input FIFOs, per-output round-robin arbiters, registered outputs.
module fifo_crossbar_switch
  import switch_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int INPUT_QTY  = 8,
  parameter int OUTPUT_QTY = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    reset,
  fifo_crossbar_switch_if.slave  bus
);
  localparam int DEST_W = dest_w(OUTPUT_QTY);
  localparam int SRC_W  = src_w(INPUT_QTY);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_W-1:0]     dest;
  } entry_t;

  logic [INPUT_QTY-1:0]  push;
  logic [INPUT_QTY-1:0]  pop;
  logic [INPUT_QTY-1:0]  fifo_full;
  logic [INPUT_QTY-1:0]  fifo_empty;
  logic [INPUT_QTY-1:0]  dest_ok;
  logic [INPUT_QTY-1:0]  drop_next;
  logic [INPUT_QTY-1:0]  drop_pulse_reg;
  entry_t                head [INPUT_QTY];
  entry_t                push_entry [INPUT_QTY];
  logic [CNT_W-1:0]      fifo_count [INPUT_QTY];

  logic [OUTPUT_QTY-1:0] slot_free;
  logic [OUTPUT_QTY-1:0] grant;
  logic [SRC_W-1:0]      grant_idx [OUTPUT_QTY];
  logic [SRC_W-1:0]      rr_ptr_reg [OUTPUT_QTY];
  logic [OUTPUT_QTY-1:0] out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg [OUTPUT_QTY];
  logic [SRC_W-1:0]      out_src_reg [OUTPUT_QTY];

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_QTY; gi++) begin : g_in
      // Invalid-destination words complete the handshake but never enter the FIFO.
      assign dest_ok[gi]          = int'(bus.in_dest[gi]) < OUTPUT_QTY;
      assign push_entry[gi]       = '{data: bus.in_data[gi], dest: bus.in_dest[gi]};
      assign push[gi]             = bus.in_valid[gi] && !fifo_full[gi] && dest_ok[gi];
      assign drop_next[gi]        = bus.in_valid[gi] && !fifo_full[gi] && !dest_ok[gi];
      assign bus.in_ready[gi]     = (fifo_count[gi] != CNT_W'(FIFO_DEPTH));
      assign bus.drop_pulse[gi]   = drop_pulse_reg[gi];

      switch_input_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push[gi]),
        .pop       (pop[gi]),
        .push_data (push_entry[gi]),
        .head      (head[gi]),
        .full      (fifo_full[gi]),
        .empty     (fifo_empty[gi]),
        .count     (fifo_count[gi])
      );
    end

    for (gi = 0; gi < OUTPUT_QTY; gi++) begin : g_out
      assign bus.out_valid[gi] = out_valid_reg[gi];
      assign bus.out_data[gi]  = out_data_reg[gi];
      assign bus.out_src[gi]   = out_src_reg[gi];
    end
  endgenerate

  // Each free output scans inputs from its pointer; a head requests only its own destination,
  // so no input can be granted by two outputs in the same cycle.
  always_comb begin
    int k;
    k         = 0;
    pop       = '0;
    grant     = '0;
    slot_free = '0;
    for (int j = 0; j < OUTPUT_QTY; j++) begin
      grant_idx[j] = '0;
      slot_free[j] = !out_valid_reg[j] || bus.out_ready[j];
      for (int off = 0; off < INPUT_QTY; off++) begin
        k = int'(rr_ptr_reg[j]) + off;
        if (k >= INPUT_QTY) k = k - INPUT_QTY;
        if (slot_free[j] && !grant[j] && !fifo_empty[k] && int'(head[k].dest) == j) begin
          grant[j]     = 1'b1;
          grant_idx[j] = SRC_W'(k);
          pop[k]       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_pulse_reg <= '0;
      out_valid_reg  <= '0;
      for (int j = 0; j < OUTPUT_QTY; j++) begin
        rr_ptr_reg[j]   <= '0;
        out_data_reg[j] <= '0;
        out_src_reg[j]  <= '0;
      end
    end else begin
      drop_pulse_reg <= drop_next;
      for (int j = 0; j < OUTPUT_QTY; j++) begin
        if (slot_free[j]) begin
          out_valid_reg[j] <= grant[j];
          if (grant[j]) begin
            out_data_reg[j] <= head[grant_idx[j]].data;
            out_src_reg[j]  <= grant_idx[j];
            rr_ptr_reg[j]   <= SRC_W'(rr_next(int'(grant_idx[j]), INPUT_QTY));
          end
        end
      end
    end
  end
endmodule
